// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART receiver types, defaults and tick-divider helper. rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   localparam int UART_DW         = 8;
   localparam int UART_OVERSAMPLE = 16;

   function automatic int tick_div(input real clock, input real baud, input int os);
      return $rtoi(clock / (baud * os));
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_tick_gen : oversample tick divider with synchronous restart. rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_tick_gen #(
   parameter int TICK_DIV = 10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   always_comb begin
      wrap   = (cnt_q == C_LAST);
      cnt_d  = cnt_q + 1'b1;
      if (restart_i || wrap) begin
         cnt_d = '0;
      end
      tick_o = wrap && !restart_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver with ready/read handshake. rev 1.0
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int  DW         = UART_DW,
   parameter real CLOCK      = 100e6,
   parameter real BAUD_RATE  = 115200,
   parameter int  OVERSAMPLE = UART_OVERSAMPLE,
   parameter int  TICK_DIV   = tick_div(CLOCK, BAUD_RATE, OVERSAMPLE)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cs,
   input  logic          Rx,
   input  logic          rd_i,
   output logic [DW-1:0] data_o,
   output logic          rx_ready_o,
   output logic          data_valid_o,
   output logic          frame_err_o,
   output logic          overrun_o
);

   localparam int              TC_W       = $clog2(OVERSAMPLE);
   localparam int              BI_W       = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [TC_W-1:0] C_HALF_M1  = TC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TC_W-1:0] C_OS_M1    = TC_W'(OVERSAMPLE - 1);
   localparam logic [BI_W-1:0] C_LAST_BIT = BI_W'(DW - 1);

   rx_state_e       state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [TC_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [BI_W-1:0] bit_idx_q, bit_idx_d;
   logic [DW-1:0]   shift_q, shift_d;
   logic [DW-1:0]   data_q, data_d;
   logic            rx_ready_q, rx_ready_d;
   logic            overrun_q, overrun_d;
   logic            data_valid_q, data_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_s, tick, restart, good;

   assign rx_s = sync_q[1];

   uart_rx_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (restart),
      .tick_o    (tick)
   );

   always_comb begin
      sync_d       = {sync_q[0], Rx};
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      rx_ready_d   = rx_ready_q;
      overrun_d    = overrun_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      restart      = 1'b0;
      good         = 1'b0;

      if (!cs) begin
         state_d    = ST_IDLE;
         tick_cnt_d = '0;
         bit_idx_d  = '0;
         restart    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // restart aligns every sample point to the detected start edge
               if (!rx_s) begin
                  state_d    = ST_START;
                  tick_cnt_d = '0;
                  restart    = 1'b1;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tick_cnt_q == C_HALF_M1) begin
                     tick_cnt_d = '0;
                     bit_idx_d  = '0;
                     state_d    = rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     tick_cnt_d = tick_cnt_q + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tick_cnt_q == C_OS_M1) begin
                     tick_cnt_d      = '0;
                     shift_d         = shift_q >> 1;
                     shift_d[DW-1]   = rx_s;
                     if (bit_idx_q == C_LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP;
                     end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tick_cnt_q == C_OS_M1) begin
                     tick_cnt_d = '0;
                     if (rx_s) begin
                        good    = 1'b1;
                        state_d = ST_IDLE;
                     end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 1'b1;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // a read landing on the completion cycle consumes the old byte, so no overrun
         if (good) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            rx_ready_d   = 1'b1;
            overrun_d    = rx_ready_q & ~rd_i;
         end else if (rd_i && rx_ready_q) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q       <= 2'b11;
         state_q      <= ST_IDLE;
         tick_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         rx_ready_q   <= 1'b0;
         overrun_q    <= 1'b0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         rx_ready_q   <= rx_ready_d;
         overrun_q    <= overrun_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data_o       = data_q;
   assign rx_ready_o   = rx_ready_q;
   assign overrun_o    = overrun_q;
   assign data_valid_o = data_valid_q;
   assign frame_err_o  = frame_err_q;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the downstream consumer of the transmitter's serial `Tx` line. It oversamples the asynchronous serial input, detects and validates the start bit, and shifts in `DW` data bits LSB-first. It checks the stop bit, then presents the byte on a parallel bus with a ready/read handshake toward the core's memory-mapped peripheral logic. Framing and overrun conditions are flagged for software.

Parameters:
- `DW`, 8, data bits per frame.
- `CLOCK`, 100e6, clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `OVERSAMPLE`, 16, sample ticks per bit. Must be even and ≥ 4.
- `TICK_DIV`, `CLOCK/(BAUD_RATE*OVERSAMPLE)`, clocks per sample tick. Integer, must be ≥ 1.

Ports:
- `clk_i`  in  1  single system clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cs`  in  1  block enable / chip select.
- `Rx`  in  1  asynchronous serial input; idle high.
- `rd_i`  in  1  one-cycle read strobe; consumes the held byte.
- `data_o`  out  DW  last received byte.
- `rx_ready_o`  out  1  level: an unread byte is held in `data_o`.
- `data_valid_o`  out  1  one-cycle pulse when a good frame completes.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit samples as 0.
- `overrun_o`  out  1  sticky: a byte completed while `rx_ready_o` was 1.

Behaviour:
- Reset (`rst_i`=1 at a clock edge): state IDLE, all counters 0, sync flops 1.
  - `data_o`=0, `rx_ready_o`=0, `data_valid_o`=0, `frame_err_o`=0, `overrun_o`=0.
  - Reset mid-frame abandons the frame; no flags are raised.
- Input synchronization: `Rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- Tick generator:
  - Free-running counter 0..`TICK_DIV`-1; `tick` is 1 for one clock on wrap.
  - Restarted at 0 on entry to START, so sample points are phase-aligned to the start edge.
- FSM states IDLE, START, DATA, STOP, BREAK. `tick_cnt` counts ticks within a bit; `bit_idx` counts data bits.
  - IDLE: `rx_s`=0 → START, with `tick_cnt`=0.
  - START: at tick `OVERSAMPLE/2`-1, sample `rx_s`.
    - 1 → false start; return to IDLE with no flags.
    - 0 → DATA, with `tick_cnt`=0 and `bit_idx`=0.
  - DATA: every `OVERSAMPLE` ticks (mid-bit), shift `rx_s` into the shift register MSB end (LSB-first frame).
    - After `bit_idx`=`DW`-1 is sampled → STOP.
  - STOP: after `OVERSAMPLE` ticks, sample `rx_s`.
    - 1 → good frame: load `data_o` from the shift register, pulse `data_valid_o`, set `rx_ready_o`, go to IDLE.
    - 0 → pulse `frame_err_o`; `data_o` and `rx_ready_o` unchanged; go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one `frame_err_o` pulse.
- Handshake:
  - `rd_i`=1 clears `rx_ready_o` next cycle.
  - A good frame completing while `rx_ready_o`=1 overwrites `data_o` and sets `overrun_o`.
  - `overrun_o` clears on `rd_i`.
  - If `rd_i` and good-frame completion land in the same cycle: new byte wins, `rx_ready_o` stays 1, `overrun_o` is not set.
  - `rd_i` while `rx_ready_o`=0 has no effect.
- Latency:
  - `data_valid_o` rises one clock after the stop-bit sample.
  - The stop-bit sample occurs at `2 + TICK_DIV*(OVERSAMPLE/2 + OVERSAMPLE*DW + OVERSAMPLE)` clocks after `Rx` falls, ±1 clock.
- Enable:
  - `cs`=0 forces IDLE and clears the tick counter, `tick_cnt` and `bit_idx`.
  - `data_o`, `rx_ready_o` and `overrun_o` hold their values.
  - Pulse outputs are 0 while `cs`=0.
  - `rd_i` is ignored while `cs`=0.
- Widths:
  - Tick counter: `$clog2(TICK_DIV)`, minimum 1.
  - `tick_cnt`: `$clog2(OVERSAMPLE)`.
  - `bit_idx`: `$clog2(DW)`.
  - Every counter wraps only under explicit FSM control.

Decomposition:
- Shared package `uart_pkg`:
  - `rx_state_e` enum (IDLE, START, DATA, STOP, BREAK).
  - Default constants `UART_DW`, `UART_OVERSAMPLE`.
  - Function `tick_div(clock, baud, os)`.
- Sub-module `uart_rx_tick_gen`: tick divider with restart input. It is the sole natural split.
- Synchronizer, FSM and shift register stay inline.

Test Plan:
Sim parameters: `CLOCK`=1.6e6, `BAUD_RATE`=10000, `OVERSAMPLE`=16 → `TICK_DIV`=10, 160 clocks per bit.
1. Frame 0xA5 with stop bit 1 → `data_o`=0xA5 and one `data_valid_o` pulse at about 1522 clocks after the falling edge. `rx_ready_o`=1 until `rd_i`, then 0.
2. `Rx` low for 50 clocks then high (glitch) → no `data_valid_o`, no `frame_err_o`; FSM back in IDLE. A following frame 0x3C is received correctly.
3. Frame 0x81 with stop bit 0, line held low 2000 clocks → exactly one `frame_err_o` pulse; `data_o` unchanged. A later frame 0x42 after the line returns high is received.
4. Two back-to-back frames 0x11 then 0x22 with no `rd_i` → `data_o`=0x22 and `overrun_o`=1. `rd_i` clears both `rx_ready_o` and `overrun_o`.
5. `rd_i` asserted in the same cycle as completion of a second frame 0x55 → `data_o`=0x55, `rx_ready_o`=1, `overrun_o`=0.
6. `rst_i` pulsed during data bit 4 of frame 0xF0, and separately `cs` dropped mid-frame → all flags 0 (reset) or held (`cs`), no pulses. A next clean frame 0x0F is received correctly.
